// File: rtl/conv_loop_counter.sv
// Three-level (channel / row / column) loop counter for convolution traversal.
// Column is innermost; ch_done marks each completed channel plane, done the whole run.
module conv_loop_counter #(
    parameter int COL_W = 6,
    parameter int ROW_W = 6,
    parameter int CH_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [COL_W-1:0] col_max,
    input  logic [ROW_W-1:0] row_max,
    input  logic [CH_W-1:0]  ch_max,
    input  logic             step,
    input  logic             abort,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic [CH_W-1:0]  ch,
    output logic             busy,
    output logic             last,
    output logic             ch_done,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [COL_W-1:0] col_reg, col_next;
    logic [ROW_W-1:0] row_reg, row_next;
    logic [CH_W-1:0]  ch_reg, ch_next;
    logic [COL_W-1:0] col_lim_reg, col_lim_next;
    logic [ROW_W-1:0] row_lim_reg, row_lim_next;
    logic [CH_W-1:0]  ch_lim_reg, ch_lim_next;
    logic             busy_reg, busy_next;
    logic             ch_done_reg, ch_done_next;
    logic             done_reg, done_next;

    logic col_at_lim;
    logic row_at_lim;
    logic ch_at_lim;

    assign col_at_lim = (col_reg == col_lim_reg);
    assign row_at_lim = (row_reg == row_lim_reg);
    assign ch_at_lim  = (ch_reg == ch_lim_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            col_reg     <= '0;
            row_reg     <= '0;
            ch_reg      <= '0;
            col_lim_reg <= '0;
            row_lim_reg <= '0;
            ch_lim_reg  <= '0;
            busy_reg    <= 1'b0;
            ch_done_reg <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            state_reg   <= state_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            ch_reg      <= ch_next;
            col_lim_reg <= col_lim_next;
            row_lim_reg <= row_lim_next;
            ch_lim_reg  <= ch_lim_next;
            busy_reg    <= busy_next;
            ch_done_reg <= ch_done_next;
            done_reg    <= done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        ch_next      = ch_reg;
        col_lim_next = col_lim_reg;
        row_lim_next = row_lim_reg;
        ch_lim_next  = ch_lim_reg;
        busy_next    = busy_reg;
        ch_done_next = 1'b0;
        done_next    = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    col_lim_next = col_max;
                    row_lim_next = row_max;
                    ch_lim_next  = ch_max;
                    col_next     = '0;
                    row_next     = '0;
                    ch_next      = '0;
                    busy_next    = 1'b1;
                    state_next   = S_RUN;
                end
            end
            S_RUN: begin
                // abort wins over a simultaneous step and suppresses both pulses
                if (abort) begin
                    col_next   = '0;
                    row_next   = '0;
                    ch_next    = '0;
                    busy_next  = 1'b0;
                    state_next = S_IDLE;
                end else if (step) begin
                    if (!col_at_lim) begin
                        col_next = col_reg + COL_W'(1);
                    end else if (!row_at_lim) begin
                        col_next = '0;
                        row_next = row_reg + ROW_W'(1);
                    end else if (!ch_at_lim) begin
                        col_next     = '0;
                        row_next     = '0;
                        ch_next      = ch_reg + CH_W'(1);
                        ch_done_next = 1'b1;
                    end else begin
                        col_next     = '0;
                        row_next     = '0;
                        ch_next      = '0;
                        busy_next    = 1'b0;
                        ch_done_next = 1'b1;
                        done_next    = 1'b1;
                        state_next   = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign col     = col_reg;
    assign row     = row_reg;
    assign ch      = ch_reg;
    assign busy    = busy_reg;
    assign ch_done = ch_done_reg;
    assign done    = done_reg;
    assign last    = busy_reg & col_at_lim & row_at_lim & ch_at_lim;

endmodule
